// File: rtl/digit_scan.sv
// Six-digit multiplexed seven-segment driver for the HH:MM:SS watch display.
// One digit is driven per scan slot onto a shared active-low segment bus, with
// an active-low anode select. All six digits and the blink mask are captured
// once per frame so a frame never shows a mix of old and new time values.
module digit_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int LEAD_BLANK   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic [3:0] sec_lo,
  input  logic [3:0] sec_hi,
  input  logic [3:0] min_lo,
  input  logic [3:0] min_hi,
  input  logic [3:0] hour_lo,
  input  logic [3:0] hour_hi,
  input  logic [5:0] blink_mask,
  output logic [7:0] seg,
  output logic [5:0] an
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] div;
  logic [2:0]       idx;
  logic [FRM_W-1:0] frame_cnt;
  logic             blink_phase;
  logic [5:0][3:0]  snap;
  logic [5:0]       snap_mask;

  logic             tick;
  logic [3:0]       cur_digit;
  logic             cur_blink;
  logic [7:0]       seg_next;
  logic [5:0]       an_next;

  // Active-low a..g pattern for one BCD value; non-decimal codes are blank.
  function automatic logic [6:0] decode7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Select the digit for the current slot; slot 0 bypasses the snapshot
  // because the snapshot is being refreshed on that very edge.
  always_comb begin
    tick      = (div == DIV_LAST);
    cur_digit = 4'd0;
    cur_blink = 1'b0;
    case (idx)
      3'd0: begin cur_digit = sec_lo;  cur_blink = blink_mask[0]; end
      3'd1: begin cur_digit = snap[1]; cur_blink = snap_mask[1];  end
      3'd2: begin cur_digit = snap[2]; cur_blink = snap_mask[2];  end
      3'd3: begin cur_digit = snap[3]; cur_blink = snap_mask[3];  end
      3'd4: begin cur_digit = snap[4]; cur_blink = snap_mask[4];  end
      3'd5: begin cur_digit = snap[5]; cur_blink = snap_mask[5];  end
      default: begin cur_digit = 4'd0; cur_blink = 1'b0; end
    endcase

    seg_next[6:0] = decode7(cur_digit);
    if ((LEAD_BLANK != 0) && (idx == 3'd5) && (cur_digit == 4'd0))
      seg_next[6:0] = 7'h7F;
    if (blink_phase && cur_blink)
      seg_next[6:0] = 7'h7F;
    // Decimal points separate HH.MM.SS and ignore blinking.
    seg_next[7] = ~((idx == 3'd2) || (idx == 3'd4));
    an_next     = ~(6'd1 << idx);
  end

  // Scan divider, digit index, frame/blink counters, snapshot and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      idx         <= 3'd0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      snap        <= '0;
      snap_mask   <= 6'd0;
      seg         <= 8'hFF;
      an          <= 6'h3F;
    end else if (!EN) begin
      // Frame counter and blink phase deliberately hold across a pause.
      div <= '0;
      idx <= 3'd0;
      seg <= 8'hFF;
      an  <= 6'h3F;
    end else if (tick) begin
      div <= '0;
      seg <= seg_next;
      an  <= an_next;
      if (idx == 3'd0) begin
        snap      <= {hour_hi, hour_lo, min_hi, min_lo, sec_hi, sec_lo};
        snap_mask <= blink_mask;
      end
      if (idx == 3'd5) begin
        idx <= 3'd0;
        if (frame_cnt == FRM_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else begin
        idx <= idx + 3'd1;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule
